// File: rtl/btn_conditioner_pkg.sv
// Shared constants and helpers for the push-button input stage.
package btn_conditioner_pkg;

  localparam int NUM_BTNS        = 4;
  localparam int BTN_IDX_W       = 2;
  localparam int TICK_W          = 16;
  localparam int DEF_DEBOUNCE_MS = 20;
  localparam int DEF_HOLD_MS     = 1000;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Index of the lowest set bit, 0 when nothing is set.
  function automatic logic [BTN_IDX_W-1:0] lowest_set(input logic [NUM_BTNS-1:0] v);
    logic [BTN_IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (v[i]) idx = BTN_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-FF synchroniser, tick-based debounce, hold timer
// and registered press/release pulses.
module btn_debounce_ch
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int HOLD_MS     = DEF_HOLD_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw_in,
  output logic level,
  output logic press,
  output logic rel,
  output logic hold
);

  localparam int DCNT_W = cnt_width(DEBOUNCE_MS);
  localparam int HCNT_W = cnt_width(HOLD_MS);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'((DEBOUNCE_MS > 0) ? DEBOUNCE_MS - 1 : 0);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(HOLD_MS);

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              stable_q, stable_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;

  // Next-state: synchroniser shift, debounce counter, hold counter, edge pulses.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    dcnt_d   = dcnt_q;

    if (DEBOUNCE_MS == 0) begin
      stable_d = sync2_q;
      dcnt_d   = '0;
    end else if (sync2_q == stable_q) begin
      dcnt_d = '0;                       // any agreement restarts the count
    end else if (tick) begin
      if (dcnt_q == DCNT_LAST) begin
        stable_d = sync2_q;
        dcnt_d   = '0;
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end

    if (!stable_q) begin
      hcnt_d = '0;
    end else if (tick && (hcnt_q != HCNT_MAX)) begin
      hcnt_d = hcnt_q + HCNT_W'(1);
    end else begin
      hcnt_d = hcnt_q;
    end

    press_d = stable_d & ~stable_q;
    rel_d   = ~stable_d & stable_q;
  end

  // State register; everything, including the synchroniser, clears on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      dcnt_q   <= '0;
      hcnt_q   <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      dcnt_q   <= dcnt_d;
      hcnt_q   <= hcnt_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
    end
  end

  assign level = stable_q;
  assign press = press_q;
  assign rel   = rel_q;
  assign hold  = stable_q && (hcnt_q == HCNT_MAX);

endmodule

// File: rtl/btn_conditioner.sv
// Push-button input stage: ms tick generator, per-button debounce channels
// and a combinational decode of the debounced levels.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int HOLD_MS     = DEF_HOLD_MS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TICK_W-1:0]    ticks_per_milli,
  input  logic                 btn_invert,
  input  logic [NUM_BTNS-1:0]  btn_raw,
  output logic [NUM_BTNS-1:0]  btn_level,
  output logic [NUM_BTNS-1:0]  btn_press,
  output logic [NUM_BTNS-1:0]  btn_release,
  output logic [NUM_BTNS-1:0]  btn_hold,
  output logic [BTN_IDX_W-1:0] btn_code,
  output logic                 btn_code_valid,
  output logic                 btn_multi
);

  localparam int POP_W = $clog2(NUM_BTNS + 1);

  logic [TICK_W-1:0]   tcnt_q, tcnt_d;
  logic [TICK_W-1:0]   period_m1;
  logic                tick;
  logic [NUM_BTNS-1:0] btn_in;
  logic [POP_W-1:0]    n_set;

  // A period of 0 behaves as 1; an overshoot after a period change ticks at once.
  assign period_m1 = (ticks_per_milli == '0) ? '0 : ticks_per_milli - TICK_W'(1);
  assign tick      = (tcnt_q >= period_m1);

  // Tick counter next state: wrap on the tick cycle.
  always_comb begin
    tcnt_d = tick ? '0 : tcnt_q + TICK_W'(1);
  end

  // Tick counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt_q <= '0;
    else     tcnt_q <= tcnt_d;
  end

  assign btn_in = btn_raw ^ {NUM_BTNS{btn_invert}};

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .HOLD_MS     (HOLD_MS)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick   (tick),
      .raw_in (btn_in[i]),
      .level  (btn_level[i]),
      .press  (btn_press[i]),
      .rel    (btn_release[i]),
      .hold   (btn_hold[i])
    );
  end

  // Decode: single-button index, validity and multi-press flag.
  always_comb begin
    n_set          = POP_W'($countones(btn_level));
    btn_code_valid = (n_set == POP_W'(1));
    btn_multi      = (n_set >= POP_W'(2));
    btn_code       = btn_code_valid ? lowest_set(btn_level) : '0;
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus a
// randomized run against a behavioural model of the button rules.
module tb_btn_conditioner;

  localparam int T   = 2;
  localparam int DEB = 3;
  localparam int HLD = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tpm, tpm2;
  logic        inv, inv2;
  logic [3:0]  raw, raw2;

  logic [3:0] btn_level, btn_press, btn_release, btn_hold;
  logic [1:0] btn_code;
  logic       btn_code_valid, btn_multi;

  logic [3:0] b_level, b_press, b_release, b_hold;
  logic [1:0] b_code;
  logic       b_valid, b_multi;

  logic [19:0] outs, outs2;
  assign outs  = {btn_level, btn_press, btn_release, btn_hold, btn_code, btn_code_valid, btn_multi};
  assign outs2 = {b_level, b_press, b_release, b_hold, b_code, b_valid, b_multi};

  int errors = 0;
  int checks = 0;

  btn_conditioner #(.DEBOUNCE_MS(DEB), .HOLD_MS(HLD)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (tpm),
    .btn_invert      (inv),
    .btn_raw         (raw),
    .btn_level       (btn_level),
    .btn_press       (btn_press),
    .btn_release     (btn_release),
    .btn_hold        (btn_hold),
    .btn_code        (btn_code),
    .btn_code_valid  (btn_code_valid),
    .btn_multi       (btn_multi)
  );

  btn_conditioner #(.DEBOUNCE_MS(0), .HOLD_MS(1)) u_byp (
    .clk             (clk),
    .rst             (rst),
    .ticks_per_milli (tpm2),
    .btn_invert      (inv2),
    .btn_raw         (raw2),
    .btn_level       (b_level),
    .btn_press       (b_press),
    .btn_release     (b_release),
    .btn_hold        (b_hold),
    .btn_code        (b_code),
    .btn_code_valid  (b_valid),
    .btn_multi       (b_multi)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    raw  = 4'b1011;
    raw2 = 4'b0110;
    repeat (3) cycle();
    checks++;
    if (outs !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 00000", outs);
    end
    checks++;
    if (outs2 !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs_bypass: got %h want 00000", outs2);
    end
    raw  = 4'b0000;
    raw2 = 4'b0000;
    rst  = 1'b0;
    repeat (20) cycle();
  endtask

  task automatic test_rst_mid_run();
    int presses;
    int first;
    int bad_rst;
    raw = 4'b0100;
    repeat (5) cycle();
    rst = 1'b1;
    bad_rst = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      if (outs !== 20'h0) bad_rst++;
    end
    checks++;
    if (bad_rst != 0) begin
      errors++;
      $display("FAIL rst_mid_outputs: %0d cycles non-zero during reset, want 0", bad_rst);
    end
    rst = 1'b0;
    presses = 0;
    first = -1;
    for (int i = 1; i <= 14; i++) begin
      cycle();
      if (btn_press[2]) presses++;
      if (first < 0 && btn_level == 4'b0100) first = i;
    end
    checks++;
    if (first < 7 || first > 9) begin
      errors++;
      $display("FAIL rst_mid_latency: level reached after %0d cycles, want 7..9", first);
    end
    checks++;
    if (presses != 1) begin
      errors++;
      $display("FAIL rst_mid_press_count: got %0d want 1", presses);
    end
    checks++;
    if (btn_level !== 4'b0100) begin
      errors++;
      $display("FAIL rst_mid_level: got %b want 0100", btn_level);
    end
  endtask

  task automatic test_bounce();
    int bad;
    int presses;
    raw = 4'b0000;
    do_reset();
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      raw[1] = ((c / 3) % 2) == 1;
      cycle();
      if (btn_press !== 4'b0000 || btn_level !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bounce_glitch: %0d cycles with activity, want 0", bad);
    end
    raw[1] = 1'b1;
    presses = 0;
    for (int c = 0; c < 15; c++) begin
      cycle();
      if (btn_press[1]) presses++;
    end
    checks++;
    if (presses != 1) begin
      errors++;
      $display("FAIL bounce_press_count: got %0d want 1", presses);
    end
    checks++;
    if ({btn_level, btn_code, btn_code_valid, btn_multi} !== {4'b0010, 2'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL bounce_decode: level=%b code=%0d valid=%b multi=%b want 0010/1/1/0",
               btn_level, btn_code, btn_code_valid, btn_multi);
    end
  endtask

  task automatic test_hold();
    int t_level;
    int t_hold;
    int t_fall;
    logic prev_hold;
    logic fall_ok;
    raw = 4'b0000;
    do_reset();
    raw = 4'b0001;
    t_level = -1;
    t_hold = -1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (t_level < 0 && btn_level[0]) t_level = c;
      if (t_hold < 0 && btn_hold[0]) t_hold = c;
    end
    checks++;
    if (t_level < 0 || t_hold < 0 || (t_hold - t_level) != HLD * T) begin
      errors++;
      $display("FAIL hold_delay: level at %0d hold at %0d, want hold %0d cycles after level",
               t_level, t_hold, HLD * T);
    end
    raw = 4'b0000;
    prev_hold = btn_hold[0];
    t_fall = -1;
    fall_ok = 1'b0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (t_fall < 0 && !btn_level[0]) begin
        t_fall = c;
        fall_ok = prev_hold && !btn_hold[0] && btn_release[0];
      end
      prev_hold = btn_hold[0];
    end
    checks++;
    if (t_fall < 0 || !fall_ok) begin
      errors++;
      $display("FAIL hold_release: fall at %0d ok=%b, want hold/level fall together with release", t_fall, fall_ok);
    end
  endtask

  task automatic test_invert();
    int bad;
    int found;
    rst = 1'b1;
    inv = 1'b1;
    raw = 4'b1111;
    repeat (3) cycle();
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 15; c++) begin
      cycle();
      if (btn_level !== 4'b0000) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL invert_idle: %0d cycles with level set, want 0", bad);
    end
    raw = 4'b0111;
    found = 0;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (btn_level == 4'b1000) found = 1;
    end
    checks++;
    if (found == 0 || {btn_level, btn_code, btn_code_valid} !== {4'b1000, 2'd3, 1'b1}) begin
      errors++;
      $display("FAIL invert_press: level=%b code=%0d valid=%b want 1000/3/1", btn_level, btn_code, btn_code_valid);
    end
    rst = 1'b1;
    inv = 1'b0;
    raw = 4'b0000;
    repeat (2) cycle();
    rst = 1'b0;
  endtask

  task automatic test_simultaneous();
    int pulse_cycles;
    logic [3:0] seen;
    raw = 4'b0000;
    do_reset();
    raw = 4'b0101;
    pulse_cycles = 0;
    seen = 4'b0000;
    for (int c = 0; c < 12; c++) begin
      cycle();
      if (btn_press != 4'b0000) begin
        pulse_cycles++;
        seen = btn_press;
      end
    end
    checks++;
    if (pulse_cycles != 1 || seen !== 4'b0101) begin
      errors++;
      $display("FAIL simul_press: %0d pulse cycles pattern %b, want 1 cycle of 0101", pulse_cycles, seen);
    end
    checks++;
    if ({btn_level, btn_multi, btn_code_valid, btn_code} !== {4'b0101, 1'b1, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL simul_decode: level=%b multi=%b valid=%b code=%0d want 0101/1/0/0",
               btn_level, btn_multi, btn_code_valid, btn_code);
    end
  endtask

  task automatic test_bypass();
    logic [3:0] hist[$];
    logic [3:0] exp_lvl;
    logic [3:0] prev_lvl;
    raw2 = 4'b0000;
    do_reset();
    hist = {4'b0000, 4'b0000};
    prev_lvl = 4'b0000;
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 1) == 1) raw2 = 4'($urandom);
      hist.push_back(raw2);
      cycle();
      exp_lvl = hist[k];
      checks++;
      if ({b_level, b_press, b_release} !== {exp_lvl, exp_lvl & ~prev_lvl, ~exp_lvl & prev_lvl}) begin
        errors++;
        $display("FAIL bypass_follow k=%0d: level/press/rel=%b/%b/%b want %b/%b/%b", k,
                 b_level, b_press, b_release, exp_lvl, exp_lvl & ~prev_lvl, ~exp_lvl & prev_lvl);
      end
      prev_lvl = exp_lvl;
    end
    raw2 = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] m_s1, m_s2, m_lvl, new_lvl, e_press, e_rel, e_hold;
    int m_dis[4];
    int m_ht[4];
    int m_idx;
    bit tk;
    logic [1:0] e_code;
    int n;
    logic [19:0] exp_v;
    raw = 4'b0000;
    do_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_idx = 0;
    for (int b = 0; b < 4; b++) begin m_dis[b] = 0; m_ht[b] = 0; end
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) raw[b] = ~raw[b];
      cycle();
      e_press = '0;
      e_rel = '0;
      if (rst) begin
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_idx = 0;
        for (int b = 0; b < 4; b++) begin m_dis[b] = 0; m_ht[b] = 0; end
      end else begin
        tk = (m_idx % T) == (T - 1);
        new_lvl = m_lvl;
        for (int b = 0; b < 4; b++) begin
          if (m_s2[b] != m_lvl[b]) begin
            if (tk) begin
              m_dis[b]++;
              if (m_dis[b] == DEB) begin
                new_lvl[b] = m_s2[b];
                m_dis[b] = 0;
              end
            end
          end else begin
            m_dis[b] = 0;
          end
          if (!m_lvl[b]) m_ht[b] = 0;
          else if (tk && m_ht[b] < HLD) m_ht[b]++;
        end
        e_press = new_lvl & ~m_lvl;
        e_rel = ~new_lvl & m_lvl;
        m_lvl = new_lvl;
        m_s2 = m_s1;
        m_s1 = raw;
        m_idx++;
      end
      for (int b = 0; b < 4; b++) e_hold[b] = m_lvl[b] && (m_ht[b] == HLD);
      n = $countones(m_lvl);
      e_code = 2'd0;
      if (n == 1)
        for (int b = 3; b >= 0; b--) if (m_lvl[b]) e_code = 2'(b);
      exp_v = {m_lvl, e_press, e_rel, e_hold, e_code, n == 1, n >= 2};
      checks++;
      if (outs !== exp_v) begin
        errors++;
        $display("FAIL random c=%0d: got %h want %h", c, outs, exp_v);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    tpm  = 16'd2;
    tpm2 = 16'd0;
    inv  = 1'b0;
    inv2 = 1'b0;
    raw  = 4'b0000;
    raw2 = 4'b0000;
    repeat (2) cycle();
    test_reset();
    test_rst_mid_run();
    test_bounce();
    test_hold();
    test_invert();
    test_simultaneous();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
